// File: rtl/wave_burst_if.sv
// Handshake and data bundle between the host/prescaler side and the
// waveform playback controller.
interface wave_burst_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] wave_len;
    logic [CNT_W-1:0]  burst_cnt;
    logic              pre_t;
    logic              pre_en;
    logic              pre_clr;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [CNT_W-1:0]  pass_cnt;

    modport master (
        output start, stop, wave_len, burst_cnt, pre_t,
        input  pre_en, pre_clr, addr, addr_valid, busy, done, aborted, pass_cnt
    );

    modport slave (
        input  start, stop, wave_len, burst_cnt, pre_t,
        output pre_en, pre_clr, addr, addr_valid, busy, done, aborted, pass_cnt
    );
endinterface

// File: rtl/wave_burst_ctrl.sv
// Waveform playback controller: arms the prescaler, steps the sample address
// on each prescaler carry and repeats the pass a programmed number of times.
module wave_burst_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    wave_burst_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [ADDR_W-1:0] len_r, len_s;
    logic [CNT_W-1:0]  pass_r, pass_s, pass_inc_s;
    logic [CNT_W-1:0]  burst_r, burst_s;
    logic              aborted_r, aborted_s;
    logic              pre_en_r, pre_clr_r, addr_valid_r, busy_r, done_r;

    // Next-state and next-datapath decode; stop outranks a coincident carry.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        pass_s     = pass_r;
        aborted_s  = aborted_r;
        len_s      = len_r;
        burst_s    = burst_r;
        pass_inc_s = pass_r + {{(CNT_W-1){1'b0}}, 1'b1};
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_s   = ST_ARM;
                    len_s     = bus.wave_len;
                    burst_s   = bus.burst_cnt;
                    addr_s    = {ADDR_W{1'b0}};
                    pass_s    = {CNT_W{1'b0}};
                    aborted_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (bus.stop) begin
                    state_s   = ST_DONE;
                    aborted_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_s   = ST_DONE;
                    aborted_s = 1'b1;
                    addr_s    = {ADDR_W{1'b0}};
                end else if (bus.pre_t) begin
                    if (addr_r == len_r) begin
                        addr_s = {ADDR_W{1'b0}};
                        pass_s = pass_inc_s;
                        if ((burst_r != {CNT_W{1'b0}}) && (pass_inc_s == burst_r)) begin
                            state_s   = ST_DONE;
                            aborted_s = 1'b0;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        addr_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output flops; outputs are decoded from the next
    // state so every output comes straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            len_r        <= {ADDR_W{1'b0}};
            pass_r       <= {CNT_W{1'b0}};
            burst_r      <= {CNT_W{1'b0}};
            aborted_r    <= 1'b0;
            pre_en_r     <= 1'b0;
            pre_clr_r    <= 1'b0;
            addr_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            addr_r       <= addr_s;
            len_r        <= len_s;
            pass_r       <= pass_s;
            burst_r      <= burst_s;
            aborted_r    <= aborted_s;
            pre_en_r     <= (state_s == ST_RUN);
            pre_clr_r    <= (state_s == ST_ARM) || (state_s == ST_DONE);
            addr_valid_r <= (state_s == ST_RUN);
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= (state_s == ST_DONE);
        end
    end

    assign bus.pre_en     = pre_en_r;
    assign bus.pre_clr    = pre_clr_r;
    assign bus.addr       = addr_r;
    assign bus.addr_valid = addr_valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.aborted    = aborted_r;
    assign bus.pass_cnt   = pass_r;

endmodule

// File: tb/tb_wave_burst_ctrl.sv
// Directed bench for wave_burst_ctrl driven by a mod-4 prescaler model with a
// registered carry; expected values are hand-computed cycle by cycle.
module tb_wave_burst_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [1:0] pre_cnt;
    logic       pre_t_q;

    wave_burst_if #(.ADDR_W(8), .CNT_W(8)) bus ();

    wave_burst_ctrl #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Mod-4 prescaler: carry registered when the count wraps.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= 2'd0;
            pre_t_q <= 1'b0;
        end else if (bus.pre_clr) begin
            pre_cnt <= 2'd0;
            pre_t_q <= 1'b0;
        end else if (bus.pre_en) begin
            pre_cnt <= pre_cnt + 2'd1;
            pre_t_q <= (pre_cnt == 2'd3);
        end else begin
            pre_t_q <= 1'b0;
        end
    end

    assign bus.pre_t = pre_t_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // {pre_en, pre_clr, addr_valid, busy, done, aborted}
    function automatic logic [31:0] flags();
        return {26'd0, bus.pre_en, bus.pre_clr, bus.addr_valid, bus.busy, bus.done, bus.aborted};
    endfunction

    // wave_len=3, burst_cnt=2: addr 0,1,2,3,0,1,2,3 at 4-cycle spacing.
    task automatic run_main(input bit poke_start);
        bus.wave_len  = 8'd3;
        bus.burst_cnt = 8'd2;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check("arm_flags", flags(), 32'h14);
        tick();
        check("run_flags", flags(), 32'h2C);
        check("run_addr0", 32'(bus.addr), 32'd0);
        repeat (4) tick();
        check("pre_step_addr", 32'(bus.addr), 32'd0);
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("step_addr", 32'(bus.addr), 32'(j % 4));
            check("step_pass", 32'(bus.pass_cnt), 32'(j / 4));
            if (j < 8) begin
                check("step_run_flags", flags(), 32'h2C);
                if (poke_start && j == 2) begin
                    bus.start     = 1'b1;
                    bus.wave_len  = 8'd0;
                    bus.burst_cnt = 8'd1;
                end
                tick();
                bus.start = 1'b0;
                check("hold_addr", 32'(bus.addr), 32'(j % 4));
                repeat (2) tick();
            end
        end
        check("burst_done_flags", flags(), 32'h16);
        tick();
        check("burst_idle_flags", flags(), 32'h00);
        check("burst_idle_pass", 32'(bus.pass_cnt), 32'd2);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.wave_len  = 8'd0;
        bus.burst_cnt = 8'd0;
        repeat (3) tick();
        check("reset_flags", flags(), 32'h00);
        check("reset_addr", 32'(bus.addr), 32'd0);
        check("reset_pass", 32'(bus.pass_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        run_main(1'b1);

        // wave_len=0, burst_cnt=1: single pass on the first carry.
        bus.wave_len  = 8'd0;
        bus.burst_cnt = 8'd1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("len0_run_flags", flags(), 32'h2C);
        tick();
        check("len0_done_flags", flags(), 32'h16);
        check("len0_pass", 32'(bus.pass_cnt), 32'd1);
        check("len0_addr", 32'(bus.addr), 32'd0);
        tick();
        check("len0_idle_flags", flags(), 32'h00);

        // Continuous, wave_len=1: stop coincides with the 12th carry (addr=1).
        bus.wave_len  = 8'd1;
        bus.burst_cnt = 8'd0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (49) tick();
        check("cont_pre_addr", 32'(bus.addr), 32'd1);
        check("cont_pre_pass", 32'(bus.pass_cnt), 32'd5);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("cont_stop_flags", flags(), 32'h17);
        check("cont_stop_pass", 32'(bus.pass_cnt), 32'd5);
        check("cont_stop_addr", 32'(bus.addr), 32'd0);
        tick();
        check("cont_idle_flags", flags(), 32'h01);

        // start with stop in IDLE is ignored.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("startstop_flags", flags(), 32'h01);
        tick();
        check("startstop_flags2", flags(), 32'h01);

        // stop during ARM: no pre_en, aborted completion one cycle later.
        bus.wave_len  = 8'd3;
        bus.burst_cnt = 8'd2;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check("armstop_arm_flags", flags(), 32'h14);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("armstop_done_flags", flags(), 32'h17);
        check("armstop_pass", 32'(bus.pass_cnt), 32'd0);
        tick();
        check("armstop_idle_flags", flags(), 32'h01);

        // Asynchronous reset mid-run at addr=2.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        check("rst_pre_addr", 32'(bus.addr), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_flags", flags(), 32'h00);
        check("async_rst_addr", 32'(bus.addr), 32'd0);
        check("async_rst_pass", 32'(bus.pass_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_flags", flags(), 32'h00);

        run_main(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wave_burst_ctrl.md
# wave_burst_ctrl

Playback controller for the waveform generator. Arms and runs the clock prescaler counter through its enable and synchronous clear inputs, consumes the prescaler carry, and steps a waveform-memory sample address from 0 to a programmable last address. It repeats the pass a programmable number of times, or indefinitely. It sits between the host control registers (start/stop, length, burst count) and the prescaler plus waveform RAM.

## Interface
- ADDR_W, 8, width of sample address and wave_len
- CNT_W, 8, width of burst count and pass counter
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin playback; honoured only in IDLE
- stop  in  1  one-cycle abort request; honoured in ARM and RUN
- wave_len  in  ADDR_W  last sample address of one pass; sampled at start
- burst_cnt  in  CNT_W  number of passes; 0 = continuous; sampled at start
- pre_t  in  1  prescaler carry, one-cycle pulse per prescaler period
- pre_en  out  1  prescaler enable
- pre_clr  out  1  prescaler synchronous clear
- addr  out  ADDR_W  current sample address to waveform RAM
- addr_valid  out  1  addr is being played (high in RUN)
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse on leaving RUN/ARM
- aborted  out  1  valid with done: 1 = ended by stop, 0 = burst completed; holds until next start
- pass_cnt  out  CNT_W  completed passes in the current run

## Operation
- Reset values: pre_en=0, pre_clr=0, addr=0, addr_valid=0, busy=0, done=0, aborted=0, pass_cnt=0, state IDLE, latched len/burst=0.
- States: IDLE, ARM, RUN, DONE.
- IDLE: outputs idle. start=1 and stop=0 -> ARM. Latch wave_len->len_q and burst_cnt->burst_q. Clear addr, pass_cnt and aborted. start=1 with stop=1 in the same cycle: stay IDLE.
- ARM (one cycle): pre_clr=1, pre_en=0. stop=1 -> DONE with aborted=1. Otherwise -> RUN.
- RUN: pre_en=1, pre_clr=0, addr_valid=1. On an edge with pre_t=1:
  - addr<len_q: addr+1.
  - addr==len_q: addr->0 and pass_cnt+1, wrapping mod 2^CNT_W.
  - If burst_q!=0 and pass_cnt+1==burst_q: -> DONE with aborted=0.
- RUN, stop=1: -> DONE with aborted=1, addr->0. stop has priority over a coincident pre_t, so no address step and no pass increment.
- DONE (one cycle): done=1, pre_clr=1, pre_en=0, addr_valid=0 -> IDLE. pass_cnt and aborted hold.
- start outside IDLE is ignored. stop in IDLE or DONE is ignored. pre_t outside RUN is ignored.
- wave_len=0: addr stays 0, and every pre_t completes a pass.
- burst_cnt=0: runs until stop; pass_cnt wraps silently.
- Changes to wave_len/burst_cnt during a run have no effect.
- rst_n low at any time: immediate return to reset values, with pre_en/pre_clr deasserted asynchronously.

## Timing
- start sampled at edge k: busy=1 and pre_clr=1 from k+1. pre_en=1 and addr_valid=1 from k+2.
- With the mod-4 prescaler, pre_t is first high in the cycle after edge k+5. The first addr step (0->1) is visible after edge k+6. Subsequent steps occur every 4 cycles.
- addr and pass_cnt update on the same edge that samples pre_t=1. Both are registered outputs, with no combinational path from inputs.
- Final pre_t of a burst at edge m: done=1 and busy=1 during m..m+1, busy=0 after edge m+1.
- stop sampled at edge s (ARM/RUN): done pulse after s. IDLE after s+1.
- A new start is accepted on the first edge where state is IDLE, i.e. the cycle after done.

## Test plan
- wave_len=3, burst_cnt=2, prescaler mod-4 -> addr sequence 0,1,2,3,0,1,2,3 at 4-cycle spacing. Single done with aborted=0, pass_cnt=2. busy falls one cycle after the final step.
- wave_len=0, burst_cnt=1 -> addr stays 0. done after the first pre_t with pass_cnt=1.
- burst_cnt=0, wave_len=1, stop issued after 5 passes in the same cycle as pre_t at addr=1 -> done with aborted=1, pass_cnt=5, addr=0.
- start and stop asserted together in IDLE -> no state change, busy stays 0. start pulsed during RUN -> sequence unaffected.
- stop during ARM -> no pre_en assertion. done with aborted=1 one cycle later.
- rst_n pulled low mid-RUN at addr=2 -> all outputs return to reset values immediately. After release, a fresh start behaves as in the first scenario.
